frame_tick_gen: RTL and testbench

- Multi-channel, parametrised frame-rate divider. Successor to the single-channel frame counter used by the game/animation FSMs.
- Each channel counts frame strobes up to a programmable period, then issues a one-cycle tick.
- Each channel runs in periodic or one-shot mode, counts its own ticks, and can be started, restarted or stopped independently.
- Sits between the VGA frame-strobe source and the block-drop/erase control FSMs.

---
 rtl/frame_tick_gen_if.sv | 27 ++
 rtl/frame_tick_gen.sv | 108 ++++++++++
 tb/tb_frame_tick_gen.sv | 117 +++++++++++
 3 files changed

// File: rtl/frame_tick_gen_if.sv
// Control and status bundle for frame_tick_gen: frame strobe, per-channel
// start/stop/mode/period in, per-channel tick/busy/frames/tick count out.
interface frame_tick_gen_if #(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned CNT_W  = 11,
    parameter int unsigned TCK_W  = 8
);
    logic                      enable;
    logic [NUM_CH-1:0]         ch_start;
    logic [NUM_CH-1:0]         ch_stop;
    logic [NUM_CH-1:0]         ch_oneshot;
    logic [NUM_CH*CNT_W-1:0]   period;
    logic [NUM_CH-1:0]         tick_out;
    logic [NUM_CH-1:0]         busy;
    logic [NUM_CH*CNT_W-1:0]   frames;
    logic [NUM_CH*TCK_W-1:0]   tick_count;

    modport master (
        output enable, ch_start, ch_stop, ch_oneshot, period,
        input  tick_out, busy, frames, tick_count
    );

    modport slave (
        input  enable, ch_start, ch_stop, ch_oneshot, period,
        output tick_out, busy, frames, tick_count
    );
endinterface

// File: rtl/frame_tick_gen.sv
// Multi-channel frame-rate divider: each channel ticks once every (P+1) frame
// strobes, periodic or one-shot, with a saturating per-channel tick counter.
module frame_tick_gen #(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned CNT_W  = 11,
    parameter int unsigned TCK_W  = 8
) (
    input  logic                  clk,
    input  logic                  reset_frame_tick,
    frame_tick_gen_if.slave       bus
);
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t             state_q  [NUM_CH];
    state_t             state_d  [NUM_CH];
    logic [CNT_W-1:0]   frames_q [NUM_CH];
    logic [CNT_W-1:0]   frames_d [NUM_CH];
    logic [CNT_W-1:0]   period_q [NUM_CH];
    logic [CNT_W-1:0]   period_d [NUM_CH];
    logic               mode_q   [NUM_CH];
    logic               mode_d   [NUM_CH];
    logic [TCK_W-1:0]   tcnt_q   [NUM_CH];
    logic [TCK_W-1:0]   tcnt_d   [NUM_CH];
    logic               tick_q   [NUM_CH];
    logic               tick_d   [NUM_CH];
    logic               term     [NUM_CH];

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (!reset_frame_tick) begin
                state_q[i]  <= IDLE;
                frames_q[i] <= '0;
                period_q[i] <= '0;
                mode_q[i]   <= 1'b0;
                tcnt_q[i]   <= '0;
                tick_q[i]   <= 1'b0;
            end else begin
                state_q[i]  <= state_d[i];
                frames_q[i] <= frames_d[i];
                period_q[i] <= period_d[i];
                mode_q[i]   <= mode_d[i];
                tcnt_q[i]   <= tcnt_d[i];
                tick_q[i]   <= tick_d[i];
            end
        end
    end

    // Terminal strobe: compare before increment, so P = all-ones cannot overflow.
    always_comb begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            term[i] = (state_q[i] == RUN) && bus.enable && (frames_q[i] == period_q[i]);
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            state_d[i] = state_q[i];
            if (bus.ch_stop[i]) begin
                state_d[i] = IDLE;
            end else if (bus.ch_start[i]) begin
                state_d[i] = RUN;
            end else if (term[i] && mode_q[i]) begin
                state_d[i] = IDLE;
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            frames_d[i] = frames_q[i];
            period_d[i] = period_q[i];
            mode_d[i]   = mode_q[i];
            tcnt_d[i]   = tcnt_q[i];
            tick_d[i]   = 1'b0;
            if (bus.ch_stop[i]) begin
                frames_d[i] = '0;
            end else if (bus.ch_start[i]) begin
                period_d[i] = bus.period[i*CNT_W +: CNT_W];
                mode_d[i]   = bus.ch_oneshot[i];
                frames_d[i] = '0;
                tcnt_d[i]   = '0;
            end else if (state_q[i] == IDLE) begin
                frames_d[i] = '0;
            end else if (term[i]) begin
                tick_d[i]   = 1'b1;
                frames_d[i] = '0;
                if (tcnt_q[i] != '1) begin
                    tcnt_d[i] = tcnt_q[i] + TCK_W'(1);
                end
            end else if (bus.enable) begin
                frames_d[i] = frames_q[i] + CNT_W'(1);
            end
        end
    end

    always_comb begin
        bus.tick_out   = '0;
        bus.busy       = '0;
        bus.frames     = '0;
        bus.tick_count = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            bus.tick_out[i]                 = tick_q[i];
            bus.busy[i]                     = (state_q[i] == RUN);
            bus.frames[i*CNT_W +: CNT_W]     = frames_q[i];
            bus.tick_count[i*TCK_W +: TCK_W] = tcnt_q[i];
        end
    end
endmodule

// File: tb/tb_frame_tick_gen.sv
// Randomized bench for frame_tick_gen against a strobe-counting reference model.
module tb_frame_tick_gen;
    localparam int NCH = 3;
    localparam int CW  = 4;
    localparam int TW  = 2;
    localparam int PMAX = (1 << CW) - 1;
    localparam int TMAX = (1 << TW) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    // Reference: strobes counted since start; ticks fall on multiples of P+1.
    bit run [NCH];
    bit os  [NCH];
    bit tk  [NCH];
    int n   [NCH];
    int p   [NCH];
    int tc  [NCH];

    frame_tick_gen_if #(.NUM_CH(NCH), .CNT_W(CW), .TCK_W(TW)) bus ();

    frame_tick_gen #(.NUM_CH(NCH), .CNT_W(CW), .TCK_W(TW)) dut (
        .clk              (clk),
        .reset_frame_tick (rst_n),
        .bus              (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input bit r, input bit en, input logic [NCH-1:0] st,
                        input logic [NCH-1:0] sp, input logic [NCH-1:0] osi,
                        input logic [NCH*CW-1:0] per);
        logic [CW-1:0] pv;
        @(negedge clk);
        rst_n          = r;
        bus.enable     = en;
        bus.ch_start   = st;
        bus.ch_stop    = sp;
        bus.ch_oneshot = osi;
        bus.period     = per;
        @(posedge clk);
        #1;
        for (int i = 0; i < NCH; i++) begin
            tk[i] = 1'b0;
            if (!r) begin
                run[i] = 0; os[i] = 0; n[i] = 0; p[i] = 0; tc[i] = 0;
            end else if (sp[i]) begin
                run[i] = 0; n[i] = 0;
            end else if (st[i]) begin
                pv = per[i*CW +: CW];
                run[i] = 1; os[i] = osi[i]; n[i] = 0; p[i] = int'(pv); tc[i] = 0;
            end else if (run[i] && en) begin
                n[i]++;
                if (n[i] % (p[i] + 1) == 0) begin
                    tk[i] = 1'b1;
                    if (tc[i] < TMAX) tc[i]++;
                    if (os[i]) begin
                        run[i] = 0; n[i] = 0;
                    end
                end
            end
        end
        for (int i = 0; i < NCH; i++) begin
            check($sformatf("busy%0d", i), int'(bus.busy[i]), int'(run[i]));
            check($sformatf("tick%0d", i), int'(bus.tick_out[i]), int'(tk[i]));
            check($sformatf("frames%0d", i), int'(bus.frames[i*CW +: CW]),
                  run[i] ? n[i] % (p[i] + 1) : 0);
            check($sformatf("tcnt%0d", i), int'(bus.tick_count[i*TW +: TW]), tc[i]);
        end
    endtask

    function automatic logic [CW-1:0] rand_period();
        case ($urandom_range(0, 3))
            0:       return '0;
            1:       return CW'(PMAX);
            2:       return CW'($urandom_range(1, 3));
            default: return CW'($urandom_range(0, PMAX));
        endcase
    endfunction

    initial begin
        logic [NCH-1:0]    st, sp, osi;
        logic [NCH*CW-1:0] per;
        bit                r, en;
        bus.enable = 0; bus.ch_start = '0; bus.ch_stop = '0;
        bus.ch_oneshot = '0; bus.period = '0;
        step(1'b0, 1'b1, '1, '0, '0, '1);
        step(1'b0, 1'b0, '0, '0, '0, '0);
        for (int k = 0; k < 10; k++) step(1'b1, 1'b1, '0, '0, '0, '1);
        // Start and stop together: stop wins.
        step(1'b1, 1'b1, '1, '1, '0, '0);
        step(1'b1, 1'b1, '0, '0, '0, '0);
        for (int k = 0; k < 4000; k++) begin
            r  = ($urandom_range(0, 399) != 0);
            en = ($urandom_range(0, 9) < 6);
            for (int i = 0; i < NCH; i++) begin
                st[i]  = ($urandom_range(0, 24) == 0);
                sp[i]  = ($urandom_range(0, 59) == 0);
                osi[i] = $urandom_range(0, 1);
                per[i*CW +: CW] = rand_period();
            end
            step(r, en, st, sp, osi, per);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
